// File: rtl/memory_stage.sv
// memory_stage: memory-access stage between execute and writeback.
// Accepts one execute instruction per handshake, issues at most one data-memory
// access (load, store, push or pop), maintains the stack pointer and registers
// the 58-bit MEM/WB bundle. Loads and pops spend one WAIT cycle on the read.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ex_valid / in_ready        execute handshake
//   ex_alu, ex_sdata,
//   ex_inport, ex_rdst, ex_ctl execute payload; ex_ctl = {rd,wr,push,pop,in,out,wb_en}
//   flush                      kill the instruction accepted / in flight
//   mem_addr, mem_re, mem_we,
//   mem_wdata, mem_rdata       synchronous data memory (rdata one cycle after re)
//   mw_bundle, mw_valid        {inport,rdata,alu,rdst,ctl} to writeback
//   stack_fault                sticky push-overflow / pop-underflow flag
module memory_stage #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              in_ready,
  input  logic [15:0]       ex_alu,
  input  logic [15:0]       ex_sdata,
  input  logic [15:0]       ex_inport,
  input  logic [2:0]        ex_rdst,
  input  logic [6:0]        ex_ctl,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [57:0]       mw_bundle,
  output logic              mw_valid,
  output logic              stack_fault
);

  localparam logic              S_IDLE  = 1'b0;
  localparam logic              S_WAIT  = 1'b1;
  localparam logic [ADDR_W-1:0] SP_INIT = '1;

  logic              r_state,  w_state_nxt;
  logic [ADDR_W-1:0] r_sp,     w_sp_nxt;
  logic [57:0]       r_bundle, w_bundle_nxt;
  logic              r_valid,  w_valid_nxt;
  logic              r_fault,  w_fault_nxt;
  logic              w_hold_load;

  // Fields of an accepted load/pop, held across the WAIT cycle
  logic [15:0] r_h_inport;
  logic [15:0] r_h_alu;
  logic [2:0]  r_h_rdst;
  logic [6:0]  r_h_ctl;

  logic       w_accept, w_go;
  logic       w_is_rd, w_is_wr, w_is_push, w_is_pop;
  logic       w_fault, w_read_op;
  logic [6:0] w_ctl, w_ctl_wb;

  assign in_ready = rst_n & (r_state == S_IDLE);
  assign w_accept = ex_valid & in_ready;
  assign w_go     = w_accept & ~flush;

  // Single memory op by priority: read > write > push > pop
  assign w_is_rd   = ex_ctl[6];
  assign w_is_wr   = ex_ctl[5] & ~ex_ctl[6];
  assign w_is_push = ex_ctl[4] & ~ex_ctl[5] & ~ex_ctl[6];
  assign w_is_pop  = ex_ctl[3] & ~ex_ctl[4] & ~ex_ctl[5] & ~ex_ctl[6];
  assign w_ctl     = {w_is_rd, w_is_wr, w_is_push, w_is_pop, ex_ctl[2:0]};

  // A faulting push/pop becomes a no-op whose writeback is suppressed
  assign w_fault   = (w_is_push & (r_sp == '0)) | (w_is_pop & (r_sp == SP_INIT));
  assign w_ctl_wb  = w_fault ? {w_ctl[6:1], 1'b0} : w_ctl;
  assign w_read_op = w_is_rd | (w_is_pop & ~w_fault);

  // Memory strobes are combinational and live only in the accept cycle
  assign mem_re    = w_go & w_read_op;
  assign mem_we    = w_go & (w_is_wr | (w_is_push & ~w_fault));
  assign mem_wdata = ex_sdata;

  always_comb begin
    mem_addr = ex_alu[ADDR_W-1:0];
    if (w_is_push)     mem_addr = r_sp;
    else if (w_is_pop) mem_addr = r_sp + ADDR_W'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_sp_nxt     = r_sp;
    w_bundle_nxt = '0;
    w_valid_nxt  = 1'b0;
    w_fault_nxt  = r_fault;
    w_hold_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          if (w_read_op) begin
            w_state_nxt = S_WAIT;
            w_hold_load = 1'b1;
          end else begin
            w_bundle_nxt = {ex_inport, 16'h0000, ex_alu, ex_rdst, w_ctl_wb};
            w_valid_nxt  = 1'b1;
            if (w_is_push && !w_fault) w_sp_nxt = r_sp - ADDR_W'(1);
            if (w_fault) w_fault_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_state_nxt = S_IDLE;
        if (!flush) begin
          w_bundle_nxt = {r_h_inport, mem_rdata, r_h_alu, r_h_rdst, r_h_ctl};
          w_valid_nxt  = 1'b1;
          // Pop commits its SP increment only here
          if (r_h_ctl[3]) w_sp_nxt = r_sp + ADDR_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sp       <= SP_INIT;
      r_bundle   <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_h_inport <= '0;
      r_h_alu    <= '0;
      r_h_rdst   <= '0;
      r_h_ctl    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sp     <= w_sp_nxt;
      r_bundle <= w_bundle_nxt;
      r_valid  <= w_valid_nxt;
      r_fault  <= w_fault_nxt;
      if (w_hold_load) begin
        r_h_inport <= ex_inport;
        r_h_alu    <= ex_alu;
        r_h_rdst   <= ex_rdst;
        r_h_ctl    <= w_ctl;
      end
    end
  end

  assign mw_bundle   = r_bundle;
  assign mw_valid    = r_valid;
  assign stack_fault = r_fault;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: table of single-cycle vectors plus directed
// sequences for loads, pops, stack faults, flush in WAIT and reset in WAIT.
module tb_memory_stage;

  localparam int unsigned ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_valid;
  logic              in_ready;
  logic [15:0]       ex_alu, ex_sdata, ex_inport;
  logic [2:0]        ex_rdst;
  logic [6:0]        ex_ctl;
  logic              flush;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re, mem_we;
  logic [15:0]       mem_wdata, mem_rdata;
  logic [57:0]       mw_bundle;
  logic              mw_valid;
  logic              stack_fault;

  int n_chk  = 0;
  int n_fail = 0;

  memory_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .in_ready(in_ready),
    .ex_alu(ex_alu), .ex_sdata(ex_sdata), .ex_inport(ex_inport),
    .ex_rdst(ex_rdst), .ex_ctl(ex_ctl), .flush(flush),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mw_bundle(mw_bundle), .mw_valid(mw_valid), .stack_fault(stack_fault)
  );

  always #5 clk = ~clk;

  // Synchronous data memory the stage talks to
  logic [15:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;
  initial mem_rdata = 16'h0000;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [57:0] mkb(input logic [15:0] inp, input logic [15:0] rd,
                                      input logic [15:0] alu, input logic [2:0] rdst,
                                      input logic [6:0] ctl);
    return {inp, rd, alu, rdst, ctl};
  endfunction

  task automatic drive(input logic v, input logic [6:0] ctl, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [15:0] inp,
                       input logic [2:0] rdst, input logic fl);
    ex_valid = v; ex_ctl = ctl; ex_alu = alu; ex_sdata = sd;
    ex_inport = inp; ex_rdst = rdst; flush = fl;
  endtask

  task automatic idle_in();
    drive(1'b0, 7'h00, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0);
  endtask

  typedef struct {
    string       name;
    logic        v;
    logic [6:0]  ctl;
    logic [15:0] alu, sd, inp;
    logic [2:0]  rdst;
    logic        fl;
    logic        e_re, e_we;
    logic [10:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_valid;
    logic [57:0] e_bundle;
    logic [10:0] e_sp;
  } vec_t;

  vec_t tv [6];

  initial begin
    tv[0] = '{"idle", 1'b0, 7'h00, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0,
              1'b0, 1'b0, 11'd0, 16'h0, 1'b0, 58'h0, 11'd2047};
    tv[1] = '{"std", 1'b1, 7'b0100000, 16'h0005, 16'hBEEF, 16'h1111, 3'd1, 1'b0,
              1'b0, 1'b1, 11'd5, 16'hBEEF, 1'b1,
              mkb(16'h1111, 16'h0, 16'h0005, 3'd1, 7'b0100000), 11'd2047};
    tv[2] = '{"alu_in", 1'b1, 7'b0000101, 16'h00AA, 16'h0, 16'hCAFE, 3'd3, 1'b0,
              1'b0, 1'b0, 11'd0, 16'h0, 1'b1,
              mkb(16'hCAFE, 16'h0, 16'h00AA, 3'd3, 7'b0000101), 11'd2047};
    tv[3] = '{"push", 1'b1, 7'b0010000, 16'h0000, 16'h1234, 16'h0, 3'd0, 1'b0,
              1'b0, 1'b1, 11'd2047, 16'h1234, 1'b1,
              mkb(16'h0, 16'h0, 16'h0, 3'd0, 7'b0010000), 11'd2046};
    tv[4] = '{"prio_wr", 1'b1, 7'b0111001, 16'h0803, 16'h5555, 16'h0, 3'd5, 1'b0,
              1'b0, 1'b1, 11'd3, 16'h5555, 1'b1,
              mkb(16'h0, 16'h0, 16'h0803, 3'd5, 7'b0100001), 11'd2046};
    tv[5] = '{"flush_acc", 1'b1, 7'b0100001, 16'h0007, 16'h0009, 16'h0, 3'd2, 1'b1,
              1'b0, 1'b0, 11'd0, 16'h0, 1'b0, 58'h0, 11'd2046};

    // Reset
    rst_n = 1'b0;
    idle_in();
    ex_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_in();
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(mw_valid), 64'd0);
    chk("rst_bundle", 64'(mw_bundle), 64'd0);
    chk("rst_sp", 64'(dut.r_sp), 64'd2047);
    chk("rst_fault", 64'(stack_fault), 64'd0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(tv[i].v, tv[i].ctl, tv[i].alu, tv[i].sd, tv[i].inp, tv[i].rdst, tv[i].fl);
      #1;
      chk({tv[i].name, "_ready"}, 64'(in_ready), 64'd1);
      chk({tv[i].name, "_re"}, 64'(mem_re), 64'(tv[i].e_re));
      chk({tv[i].name, "_we"}, 64'(mem_we), 64'(tv[i].e_we));
      if (tv[i].e_re || tv[i].e_we) chk({tv[i].name, "_addr"}, 64'(mem_addr), 64'(tv[i].e_addr));
      if (tv[i].e_we) chk({tv[i].name, "_wdata"}, 64'(mem_wdata), 64'(tv[i].e_wdata));
      @(posedge clk);
      #1;
      chk({tv[i].name, "_valid"}, 64'(mw_valid), 64'(tv[i].e_valid));
      chk({tv[i].name, "_bundle"}, 64'(mw_bundle), 64'(tv[i].e_bundle));
      chk({tv[i].name, "_sp"}, 64'(dut.r_sp), 64'(tv[i].e_sp));
    end

    // LDD from address 5 written with BEEF above
    @(negedge clk);
    drive(1'b1, 7'b1000001, 16'h0005, 16'h0, 16'h0, 3'd2, 1'b0);
    #1;
    chk("ldd_re", 64'(mem_re), 64'd1);
    chk("ldd_addr", 64'(mem_addr), 64'd5);
    @(posedge clk); #1;
    chk("ldd_wait_ready", 64'(in_ready), 64'd0);
    chk("ldd_wait_valid", 64'(mw_valid), 64'd0);
    @(negedge clk);
    idle_in();
    #1;
    chk("ldd_wait_re", 64'(mem_re), 64'd0);
    @(posedge clk); #1;
    chk("ldd_valid", 64'(mw_valid), 64'd1);
    chk("ldd_bundle", 64'(mw_bundle), 64'(mkb(16'h0, 16'hBEEF, 16'h0005, 3'd2, 7'b1000001)));
    chk("ldd_ready_after", 64'(in_ready), 64'd1);

    // Read wins over write and push
    @(negedge clk);
    drive(1'b1, 7'b1110001, 16'h0005, 16'h7777, 16'h0, 3'd6, 1'b0);
    #1;
    chk("prio_rd_re", 64'(mem_re), 64'd1);
    chk("prio_rd_we", 64'(mem_we), 64'd0);
    @(posedge clk);
    @(negedge clk);
    idle_in();
    @(posedge clk); #1;
    chk("prio_rd_bundle", 64'(mw_bundle), 64'(mkb(16'h0, 16'hBEEF, 16'h0005, 3'd6, 7'b1000001)));
    chk("prio_rd_sp", 64'(dut.r_sp), 64'd2046);

    // POP of the 0x1234 pushed earlier
    @(negedge clk);
    drive(1'b1, 7'b0001001, 16'h0, 16'h0, 16'h0, 3'd4, 1'b0);
    #1;
    chk("pop_re", 64'(mem_re), 64'd1);
    chk("pop_addr", 64'(mem_addr), 64'd2047);
    @(posedge clk); #1;
    chk("pop_wait_sp", 64'(dut.r_sp), 64'd2046);
    @(negedge clk);
    idle_in();
    @(posedge clk); #1;
    chk("pop_valid", 64'(mw_valid), 64'd1);
    chk("pop_bundle", 64'(mw_bundle), 64'(mkb(16'h0, 16'h1234, 16'h0, 3'd4, 7'b0001001)));
    chk("pop_sp", 64'(dut.r_sp), 64'd2047);

    // POP at SP_INIT underflows
    @(negedge clk);
    drive(1'b1, 7'b0001001, 16'h0, 16'h0, 16'h0, 3'd4, 1'b0);
    #1;
    chk("popf_re", 64'(mem_re), 64'd0);
    @(posedge clk); #1;
    chk("popf_fault", 64'(stack_fault), 64'd1);
    chk("popf_valid", 64'(mw_valid), 64'd1);
    chk("popf_bundle", 64'(mw_bundle), 64'(mkb(16'h0, 16'h0, 16'h0, 3'd4, 7'b0001000)));
    chk("popf_sp", 64'(dut.r_sp), 64'd2047);
    chk("popf_ready", 64'(in_ready), 64'd1);

    // LDD flushed in its WAIT cycle
    @(negedge clk);
    drive(1'b1, 7'b1000001, 16'h0005, 16'h0, 16'h0, 3'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    idle_in();
    flush = 1'b1;
    @(posedge clk); #1;
    chk("fl_wait_valid", 64'(mw_valid), 64'd0);
    chk("fl_wait_bundle", 64'(mw_bundle), 64'd0);
    chk("fl_wait_ready", 64'(in_ready), 64'd1);
    chk("fl_wait_sp", 64'(dut.r_sp), 64'd2047);
    @(negedge clk);
    idle_in();

    // Fill the stack down to SP=0, then overflow
    for (int k = 0; k < 2047; k++) begin
      @(negedge clk);
      drive(1'b1, 7'b0010000, 16'h0, 16'(k), 16'h0, 3'd0, 1'b0);
    end
    @(negedge clk);
    idle_in();
    #1;
    chk("fill_sp", 64'(dut.r_sp), 64'd0);
    drive(1'b1, 7'b0010001, 16'h0, 16'hDEAD, 16'h0, 3'd0, 1'b0);
    #1;
    chk("pushf_we", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    chk("pushf_bundle", 64'(mw_bundle), 64'(mkb(16'h0, 16'h0, 16'h0, 3'd0, 7'b0010000)));
    chk("pushf_sp", 64'(dut.r_sp), 64'd0);

    // Reset while in WAIT
    @(negedge clk);
    drive(1'b1, 7'b1000001, 16'h0005, 16'h0, 16'h0, 3'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    idle_in();
    rst_n = 1'b0;
    #1;
    chk("rstw_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rstw_valid", 64'(mw_valid), 64'd0);
    chk("rstw_sp", 64'(dut.r_sp), 64'd2047);
    chk("rstw_fault", 64'(stack_fault), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstw_ready_after", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
